// File: rtl/affine_interp_acc.sv
// Multi-tap interpolation accumulator: shift-and-add products over the 15-entry
// affine coefficient set, NTAPS-tap accumulation, round/clip, valid/ready output.
module affine_interp_acc #(
  parameter int NTAPS = 4,   // taps per output pixel, 2..8
  parameter int ACC_W = 18   // must be >= 16 + clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] in_sample,
  input  logic [3:0]        in_coef_idx,
  input  logic              in_coef_neg,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_pixel,
  output logic              out_short
);

  localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(32);

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              out_pixel_q, out_pixel_d;
  logic                    out_short_q, out_short_d;

  logic                    tap_xfer;
  logic                    out_xfer;
  logic                    group_end;
  logic signed [15:0]      mag_prod;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sum_rnd;
  logic signed [ACC_W-1:0] rounded;
  logic [7:0]              pixel_clip;

  // Each coefficient decomposed into at most four shifted terms of the sample.
  function automatic logic signed [15:0] coef_mul(input logic signed [7:0] smp,
                                                   input logic [3:0]        idx);
    logic signed [15:0] s;
    logic signed [15:0] p;
    s = {{8{smp[7]}}, smp};
    p = '0;
    case (idx)
      4'd0:  p = '0;
      4'd1:  p = s << 2;                                  // 4
      4'd2:  p = s << 3;                                  // 8
      4'd3:  p = (s << 3) + (s << 2) + s;                 // 13
      4'd4:  p = (s << 4) + s;                            // 17
      4'd5:  p = (s << 4) + (s << 3) + (s << 1);          // 26
      4'd6:  p = (s << 5) - s;                            // 31
      4'd7:  p = (s << 5) + (s << 1);                     // 34
      4'd8:  p = (s << 5) + (s << 3);                     // 40
      4'd9:  p = (s << 5) + (s << 3) + (s << 2) + s;      // 45
      4'd10: p = (s << 5) + (s << 4) - s;                 // 47
      4'd11: p = (s << 5) + (s << 4) + (s << 2);          // 52
      4'd12: p = (s << 6) - (s << 2) - (s << 1);          // 58
      4'd13: p = (s << 6) - (s << 2);                     // 60
      4'd14: p = (s << 6) - (s << 1);                     // 62
      4'd15: p = (s << 6) - s;                            // 63
      default: p = '0;
    endcase
    return p;
  endfunction

  always_comb begin
    mag_prod = coef_mul(in_sample, in_coef_idx);
    prod     = in_coef_neg ? -mag_prod : mag_prod;
    prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    sum      = acc_q + prod_ext;
    sum_rnd  = sum + RND_BIAS;
    rounded  = sum_rnd >>> 6;
    if (rounded[ACC_W-1])            pixel_clip = 8'd0;
    else if (|rounded[ACC_W-2:8])    pixel_clip = 8'd255;
    else                             pixel_clip = rounded[7:0];
  end

  assign tap_xfer  = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign group_end = in_last || (tap_cnt_q == LAST_TAP);

  // State register: reset discards any partial group and any held pixel.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ACC;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      out_pixel_q <= '0;
      out_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      out_pixel_q <= out_pixel_d;
      out_short_q <= out_short_d;
    end
  end

  // Next-state logic.
  // NOTE: default assignment first so no path through the block infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACC:   if (tap_xfer && group_end) state_d = S_OUT;
      S_OUT:   if (out_xfer)              state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  // Datapath next values; tap_xfer can only occur in S_ACC.
  always_comb begin
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    out_pixel_d = out_pixel_q;
    out_short_d = out_short_q;
    if (tap_xfer) begin
      if (group_end) begin
        acc_d       = '0;
        tap_cnt_d   = '0;
        out_pixel_d = pixel_clip;
        out_short_d = (tap_cnt_q < LAST_TAP);
      end else begin
        acc_d     = sum;
        tap_cnt_d = tap_cnt_q + 1'b1;
      end
    end
  end

  // Outputs decoded from state only; no combinational path from out_ready.
  always_comb begin
    in_ready  = (state_q == S_ACC);
    out_valid = (state_q == S_OUT);
    out_pixel = out_pixel_q;
    out_short = out_short_q;
  end

endmodule

// File: tb/tb_affine_interp_acc.sv
// Self-checking bench for affine_interp_acc: directed vector table, corner-case
// sequences (backpressure, reset) and random groups against an arithmetic model.
module tb_affine_interp_acc;

  localparam int NTAPS = 4;
  localparam int ACC_W = 18;
  localparam int COEF[16] = '{0, 4, 8, 13, 17, 26, 31, 34, 40, 45, 47, 52, 58, 60, 62, 63};

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_sample;
  logic [3:0]        in_coef_idx;
  logic              in_coef_neg;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pixel;
  logic              out_short;

  int n_tests = 0;
  int n_fail  = 0;

  affine_interp_acc #(.NTAPS(NTAPS), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .in_coef_idx (in_coef_idx),
    .in_coef_neg (in_coef_neg),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_short   (out_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    int             n;          // taps actually sent
    logic           last4;      // assert in_last on a full group's final tap
    logic [3:0][7:0] s;
    logic [3:0][3:0] idx;
    logic [3:0]     neg;
    int             exp_pix;
    int             exp_short;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: plain integer multiply, sum, floor-divide by 64 after +32, clip.
  function automatic void model(input vec_t v, output int pix, output int shrt);
    int sum;
    int p;
    int r;
    sum = 0;
    for (int k = 0; k < v.n; k++) begin
      p = int'($signed(v.s[k])) * COEF[v.idx[k]];
      if (v.neg[k]) p = -p;
      sum += p;
    end
    r    = (sum + 32) >>> 6;
    pix  = (r < 0) ? 0 : (r > 255) ? 255 : r;
    shrt = (v.n < NTAPS) ? 1 : 0;
  endfunction

  task automatic send_tap(input logic signed [7:0] s, input logic [3:0] idx,
                          input logic neg, input logic last);
    logic was_ready;
    int   budget;
    in_valid    = 1'b1;
    in_sample   = s;
    in_coef_idx = idx;
    in_coef_neg = neg;
    in_last     = last;
    budget      = 50;
    do begin
      was_ready = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!was_ready && budget > 0);
    if (!was_ready) check("tap_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends one group, checks latency/result, holds out_ready low for 'hold' cycles,
  // then completes the output handshake.
  task automatic run_group(input vec_t v, input int exp_pix, input int exp_short,
                           input int hold);
    logic last;
    for (int k = 0; k < v.n; k++) begin
      last = (k == v.n - 1) && ((v.n < NTAPS) || v.last4);
      send_tap($signed(v.s[k]), v.idx[k], v.neg[k], last);
    end
    check({v.name, "_valid_latency"}, int'(out_valid), 1);
    check({v.name, "_pixel"}, int'(out_pixel), exp_pix);
    check({v.name, "_short"}, int'(out_short), exp_short);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check({v.name, "_hold_pixel"}, int'(out_pixel), exp_pix);
      check({v.name, "_hold_in_ready"}, int'(in_ready), 0);
      check({v.name, "_hold_valid"}, int'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({v.name, "_valid_drop"}, int'(out_valid), 0);
    check({v.name, "_in_ready_back"}, int'(in_ready), 1);
  endtask

  function automatic vec_t mk(input string name, input int n, input logic last4,
                              input int s0, input int i0, input int n0,
                              input int s1, input int i1, input int n1,
                              input int s2, input int i2, input int n2,
                              input int s3, input int i3, input int n3,
                              input int ep, input int es);
    vec_t v;
    v.name = name; v.n = n; v.last4 = last4;
    v.s[0] = 8'(s0); v.idx[0] = 4'(i0); v.neg[0] = 1'(n0);
    v.s[1] = 8'(s1); v.idx[1] = 4'(i1); v.neg[1] = 1'(n1);
    v.s[2] = 8'(s2); v.idx[2] = 4'(i2); v.neg[2] = 1'(n2);
    v.s[3] = 8'(s3); v.idx[3] = 4'(i3); v.neg[3] = 1'(n3);
    v.exp_pix = ep; v.exp_short = es;
    return v;
  endfunction

  vec_t vecs[6];
  vec_t rv;
  int   mp, ms;

  initial begin
    // Expected values derived by hand from the coefficient table.
    vecs[0] = mk("bilinear", 4, 1'b0, 100, 13, 0,  20, 1, 0,   0, 0, 0,   0, 0, 0,  95, 0);
    vecs[1] = mk("rounding", 4, 1'b1, 100, 13, 0, 100, 2, 0,   0, 0, 0,   0, 0, 0, 106, 0);
    vecs[2] = mk("high_clip", 4, 1'b0, 127, 15, 0, 127, 15, 0, 127, 15, 0, 127, 15, 0, 255, 0);
    vecs[3] = mk("low_clip", 1, 1'b1, -100, 15, 0,  0, 0, 0,   0, 0, 0,   0, 0, 0,   0, 1);
    vecs[4] = mk("neg_coef", 4, 1'b0, 100, 15, 0,  50, 14, 1,  0, 0, 0,   0, 0, 0,  50, 0);
    vecs[5] = mk("two_tap", 2, 1'b0, -128, 15, 1,  64, 3, 0,   0, 0, 0,   0, 0, 0, 139, 1);

    rst = 1'b1; in_valid = 1'b0; in_sample = '0; in_coef_idx = '0;
    in_coef_neg = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #23;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_pixel", int'(out_pixel), 0);
    check("reset_out_short", int'(out_short), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 6; i++)
      run_group(vecs[i], vecs[i].exp_pix, vecs[i].exp_short, (i == 0) ? 5 : 0);

    // Reset mid-group after two taps; the following group must ignore them.
    send_tap(8'sd127, 4'd15, 1'b0, 1'b0);
    send_tap(8'sd127, 4'd15, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("rst_mid_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    #1;
    check("rst_mid_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    run_group(vecs[0], 95, 0, 0);

    // Reset while an output is being held.
    for (int k = 0; k < NTAPS; k++)
      send_tap($signed(vecs[0].s[k]), vecs[0].idx[k], vecs[0].neg[k], 1'b0);
    check("rst_hold_pre_valid", int'(out_valid), 1);
    rst = 1'b1;
    #2;
    check("rst_hold_out_valid", int'(out_valid), 0);
    check("rst_hold_out_pixel", int'(out_pixel), 0);
    check("rst_hold_out_short", int'(out_short), 0);
    rst = 1'b0;
    #1;
    check("rst_hold_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    run_group(vecs[4], 50, 0, 0);

    // Random groups against the model.
    for (int g = 0; g < 60; g++) begin
      rv.name  = "random";
      rv.n     = int'($urandom_range(1, NTAPS));
      rv.last4 = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        rv.s[k]   = 8'($urandom);
        rv.idx[k] = 4'($urandom);
        rv.neg[k] = 1'($urandom);
      end
      model(rv, mp, ms);
      run_group(rv, mp, ms, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
